row_max_sub: RTL

//  Softmax front end for the attention datapath. Collects one score row of ROW_LEN

---
 rtl/row_max_sub_pkg.sv | 15 +
 rtl/row_max_sub_if.sv | 28 ++
 rtl/row_max_sub_sel_max.sv | 31 +++
 rtl/row_max_sub.sv | 105 ++++++++++
 4 files changed

// File: rtl/row_max_sub_pkg.sv
// Shared definitions for the softmax front end: row geometry, default element
// width and the row-processing state encoding reused by later softmax stages.
package row_max_sub_pkg;

    localparam int ROW_LEN = 16;
    localparam int D_W_DEF = 16;
    localparam int CNT_W   = $clog2(ROW_LEN);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        MAX     = 2'd1,
        EMIT    = 2'd2
    } state_t;

endpackage

// File: rtl/row_max_sub_if.sv
// Element stream interface: upstream score input, downstream (x - max) output
// and the registered row maximum.
interface row_max_sub_if
    import row_max_sub_pkg::*;
#(
    parameter int D_W = D_W_DEF
) ();

    logic                  I_VLD;
    logic signed [D_W-1:0] I_DATA;
    logic                  O_RDY;
    logic                  O_VLD;
    logic signed [D_W-1:0] O_DATA;
    logic                  O_LAST;
    logic signed [D_W-1:0] O_MAX;
    logic                  I_RDY;

    modport slave (
        input  I_VLD, I_DATA, I_RDY,
        output O_RDY, O_VLD, O_DATA, O_LAST, O_MAX
    );

    modport master (
        output I_VLD, I_DATA, I_RDY,
        input  O_RDY, O_VLD, O_DATA, O_LAST, O_MAX
    );

endinterface

// File: rtl/row_max_sub_sel_max.sv
// sel_max: 16-input signed maximum as a four-level combinational compare tree.
module sel_max
    import row_max_sub_pkg::*;
#(
    parameter int D_W = D_W_DEF
) (
    input  logic signed [D_W-1:0] din_i [ROW_LEN],
    output logic signed [D_W-1:0] max_o
);

    logic signed [D_W-1:0] lvl1 [ROW_LEN/2];
    logic signed [D_W-1:0] lvl2 [ROW_LEN/4];
    logic signed [D_W-1:0] lvl3 [ROW_LEN/8];

    // Ties keep the left operand; the value is identical either way.
    function automatic logic signed [D_W-1:0] smax(
        input logic signed [D_W-1:0] a,
        input logic signed [D_W-1:0] b
    );
        return (b > a) ? b : a;
    endfunction

    // Pairwise reduction, one array per tree level.
    always_comb begin
        for (int i = 0; i < ROW_LEN/2; i++) lvl1[i] = smax(din_i[2*i], din_i[2*i+1]);
        for (int i = 0; i < ROW_LEN/4; i++) lvl2[i] = smax(lvl1[2*i], lvl1[2*i+1]);
        for (int i = 0; i < ROW_LEN/8; i++) lvl3[i] = smax(lvl2[2*i], lvl2[2*i+1]);
        max_o = smax(lvl3[0], lvl3[1]);
    end

endmodule

// File: rtl/row_max_sub.sv
// row_max_sub: buffers one score row, finds its maximum in a single cycle and
// streams back saturated (x_i - max) for the exp stage. Rows do not overlap.
module row_max_sub
    import row_max_sub_pkg::*;
#(
    parameter int D_W = D_W_DEF
) (
    input  logic         I_CLK,
    input  logic         I_RST,
    row_max_sub_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ROW_LEN - 1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
    logic signed [D_W-1:0] max_q;
    logic signed [D_W-1:0] tree_max;
    logic signed [D_W-1:0] row_buf_q [ROW_LEN];
    logic signed [D_W:0]   diff;
    logic                  wr_en;
    logic                  max_ld;
    logic                  emit;

    // The difference of two in-range values can only overflow downwards because
    // max_q is the row maximum; both directions are clamped for safety anyway.
    function automatic logic signed [D_W-1:0] sat_diff(input logic signed [D_W:0] d);
        if (d[D_W] != d[D_W-1])
            return d[D_W] ? {1'b1, {(D_W-1){1'b0}}} : {1'b0, {(D_W-1){1'b1}}};
        return d[D_W-1:0];
    endfunction

    sel_max #(.D_W(D_W)) u_sel_max (
        .din_i (row_buf_q),
        .max_o (tree_max)
    );

    // Next-state, counter and strobe decode for the COLLECT/MAX/EMIT sequence.
    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        wr_en    = 1'b0;
        max_ld   = 1'b0;
        case (state_q)
            COLLECT: begin
                if (bus.I_VLD) begin
                    wr_en = 1'b1;
                    if (wr_cnt_q == LAST_IDX) begin
                        wr_cnt_d = '0;
                        state_d  = MAX;
                    end else begin
                        wr_cnt_d = wr_cnt_q + CNT_W'(1);
                    end
                end
            end
            MAX: begin
                max_ld  = 1'b1;
                state_d = EMIT;
            end
            EMIT: begin
                if (bus.I_RDY) begin
                    if (rd_cnt_q == LAST_IDX) begin
                        rd_cnt_d = '0;
                        state_d  = COLLECT;
                    end else begin
                        rd_cnt_d = rd_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // Control state and the row maximum; a reset abandons any partial row.
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            state_q  <= COLLECT;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            max_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            if (max_ld) max_q <= tree_max;
        end
    end

    // Row buffer holds data only, so it carries no reset.
    always_ff @(posedge I_CLK) begin
        if (wr_en) row_buf_q[wr_cnt_q] <= bus.I_DATA;
    end

    assign emit = (state_q == EMIT);
    assign diff = (D_W+1)'(row_buf_q[rd_cnt_q]) - (D_W+1)'(max_q);

    assign bus.O_RDY  = (state_q == COLLECT);
    assign bus.O_VLD  = emit;
    assign bus.O_LAST = emit && (rd_cnt_q == LAST_IDX);
    assign bus.O_MAX  = max_q;
    assign bus.O_DATA = emit ? sat_diff(diff) : '0;

endmodule
